spi_target: RTL and testbench

- SPI responder (mode CPHA=0) for the far end of the expansion board's bit-banged SPI port, i.e. the device behind /SS0 or /SS1.
- Oversamples SCK/MOSI/nSS on a local system clock. Exposes a small byte register file the Gigatron reads and writes with a command byte followed by auto-incrementing data bytes.
- Used by on-board peripherals and as a known-good target for port-level regression.

---
 rtl/spi_target.sv | 138 +++++++++++++
 tb/tb_spi_target.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI responder (CPHA=0) with an oversampled host interface and a byte register
// file accessed by a command byte followed by auto-incrementing data bytes.
module spi_target #(
  parameter int         NREGS  = 16,
  parameter int         AW     = 4,
  parameter bit         CPOL   = 1'b0,
  parameter logic [7:0] RSTVAL = 8'h00
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  input  logic                 SCK,
  input  logic                 MOSI,
  input  logic                 nSS,
  output logic                 MISO,
  output logic                 MISO_EN,
  input  logic [7:0]           STATUS,
  output logic [NREGS*8-1:0]   REGS,
  output logic                 WSTB,
  output logic [AW-1:0]        WADDR,
  output logic [7:0]           WDATA,
  output logic                 BUSY
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t        state;
  logic [2:0]    sck_s;
  logic [2:0]    nss_s;
  logic [1:0]    mosi_s;
  logic [2:0]    bit_cnt;
  logic [AW-1:0] addr;
  logic          wr_mode;
  logic [6:0]    rx_sr;
  logic [8:0]    tx_sr;
  logic [7:0]    regs [NREGS];

  logic          sck_rise, sck_fall, lead_edge, trail_edge;
  logic          nss_fall, nss_rise, mosi_bit;
  logic [7:0]    rx_byte;
  logic [AW-1:0] addr_next;

  // nSS synchroniser resets to "selected" so a host still holding nSS low after
  // a mid-transfer reset does not produce a false falling edge.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sck_s  <= {3{CPOL}};
      nss_s  <= '0;
      mosi_s <= '0;
    end else begin
      sck_s  <= {sck_s[1:0], SCK};
      nss_s  <= {nss_s[1:0], nSS};
      mosi_s <= {mosi_s[0], MOSI};
    end
  end

  assign sck_rise   = sck_s[1] & ~sck_s[2];
  assign sck_fall   = ~sck_s[1] & sck_s[2];
  assign lead_edge  = CPOL ? sck_fall : sck_rise;
  assign trail_edge = CPOL ? sck_rise : sck_fall;
  assign nss_fall   = ~nss_s[1] & nss_s[2];
  assign nss_rise   = nss_s[1] & ~nss_s[2];
  assign mosi_bit   = mosi_s[1];
  assign rx_byte    = {rx_sr, mosi_bit};
  assign addr_next  = addr + AW'(1);

  // tx_sr[8] is the bit on MISO; loading a new byte keeps it so the byte's MSB
  // only appears after the next trailing edge.
  assign MISO = tx_sr[8];

  for (genvar i = 0; i < NREGS; i++) begin : g_regs
    assign REGS[8*i +: 8] = regs[i];
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state   <= IDLE;
      bit_cnt <= '0;
      addr    <= '0;
      wr_mode <= 1'b0;
      rx_sr   <= '0;
      tx_sr   <= 9'h100;
      MISO_EN <= 1'b0;
      WSTB    <= 1'b0;
      WADDR   <= '0;
      WDATA   <= '0;
      BUSY    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= RSTVAL;
    end else begin
      WSTB <= 1'b0;
      if (nss_rise) begin
        state    <= IDLE;
        BUSY     <= 1'b0;
        MISO_EN  <= 1'b0;
        tx_sr[8] <= 1'b1;
        bit_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (nss_fall) begin
              tx_sr   <= {STATUS, 1'b0};
              MISO_EN <= 1'b1;
              bit_cnt <= '0;
              state   <= CMD;
              BUSY    <= 1'b1;
            end
          end
          CMD, DATA: begin
            if (lead_edge) begin
              rx_sr   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == CMD) begin
                  wr_mode <= rx_byte[7];
                  addr    <= rx_byte[AW-1:0];
                  tx_sr   <= {tx_sr[8], regs[rx_byte[AW-1:0]]};
                  state   <= DATA;
                end else begin
                  if (wr_mode) begin
                    regs[addr] <= rx_byte;
                    WSTB       <= 1'b1;
                    WADDR      <= addr;
                    WDATA      <= rx_byte;
                  end
                  addr  <= addr_next;
                  tx_sr <= {tx_sr[8], regs[addr_next]};
                end
              end
            end else if (trail_edge) begin
              tx_sr <= {tx_sr[7:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: expected MISO bytes and register writes are
// queued by the stimulus and consumed by a monitor as the DUT produces them.
module tb_spi_target;

  localparam int NREGS = 16;
  localparam int AW    = 4;

  logic               CLK = 1'b0;
  logic               nRESET = 1'b0;
  logic               SCK = 1'b0;
  logic               MOSI = 1'b0;
  logic               nSS = 1'b1;
  logic               MISO;
  logic               MISO_EN;
  logic [7:0]         STATUS = 8'h00;
  logic [NREGS*8-1:0] REGS;
  logic               WSTB;
  logic [AW-1:0]      WADDR;
  logic [7:0]         WDATA;
  logic               BUSY;

  int checks = 0;
  int errors = 0;

  logic [7:0]      exp_miso_q [$];
  logic [7:0]      got_miso_q [$];
  logic [AW+7:0]   exp_wr_q [$];

  spi_target #(.NREGS(NREGS), .AW(AW), .CPOL(1'b0), .RSTVAL(8'h00)) dut (
    .CLK(CLK), .nRESET(nRESET), .SCK(SCK), .MOSI(MOSI), .nSS(nSS),
    .MISO(MISO), .MISO_EN(MISO_EN), .STATUS(STATUS), .REGS(REGS),
    .WSTB(WSTB), .WADDR(WADDR), .WDATA(WDATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Clocks nbits of mosi_byte MSB-first; a full byte is handed to the monitor.
  task automatic apply_stimulus(input logic [7:0] mosi_byte, input int nbits,
                                input logic [7:0] exp_miso);
    logic [7:0] got = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      MOSI = mosi_byte[i];
      wait_clk(6);
      got[i] = MISO;
      SCK = 1'b1;
      wait_clk(6);
      SCK = 1'b0;
    end
    if (nbits == 8) begin
      exp_miso_q.push_back(exp_miso);
      got_miso_q.push_back(got);
    end
  endtask

  task automatic select_dut();
    nSS = 1'b0;
    wait_clk(8);
  endtask

  task automatic deselect_dut();
    nSS = 1'b1;
    wait_clk(8);
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  task automatic check_reg(input int idx, input logic [7:0] exp);
    check_output($sformatf("reg%0d", idx), 32'(REGS[8*idx +: 8]), 32'(exp));
  endtask

  task automatic monitor_loop();
    logic [AW+7:0] wr;
    logic [7:0]    g, e;
    forever begin
      @(negedge CLK);
      if (nRESET && WSTB) begin
        if (exp_wr_q.size() == 0) begin
          check_output("unexpected_wstb", {20'h0, WADDR, WDATA}, 32'hFFFFFFFF);
        end else begin
          wr = exp_wr_q.pop_front();
          check_output("wstb_addr_data", 32'({WADDR, WDATA}), 32'(wr));
        end
      end
      if (got_miso_q.size() > 0) begin
        g = got_miso_q.pop_front();
        e = exp_miso_q.pop_front();
        check_output("miso_byte", 32'(g), 32'(e));
      end
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fork
      monitor_loop();
    join_none

    wait_clk(3);
    check_output("reset_miso", 32'(MISO), 32'd1);
    check_output("reset_miso_en", 32'(MISO_EN), 32'd0);
    check_output("reset_busy", 32'(BUSY), 32'd0);
    check_output("reset_wstb", 32'(WSTB), 32'd0);
    nRESET = 1'b1;
    wait_clk(4);

    $display("[TB] status readback");
    STATUS = 8'h5A;
    select_dut();
    check_output("sel_miso_en", 32'(MISO_EN), 32'd1);
    check_output("sel_busy", 32'(BUSY), 32'd1);
    apply_stimulus(8'h00, 8, 8'h5A);
    deselect_dut();
    check_output("desel_busy", 32'(BUSY), 32'd0);

    $display("[TB] write reg3/reg4");
    select_dut();
    apply_stimulus(8'h83, 8, 8'h5A);
    expect_write(4'd3, 8'hC3);
    apply_stimulus(8'hC3, 8, 8'h00);
    expect_write(4'd4, 8'h3C);
    apply_stimulus(8'h3C, 8, 8'h00);
    deselect_dut();
    check_reg(3, 8'hC3);
    check_reg(4, 8'h3C);

    $display("[TB] read reg3/reg4");
    select_dut();
    apply_stimulus(8'h03, 8, 8'h5A);
    apply_stimulus(8'h00, 8, 8'hC3);
    apply_stimulus(8'h00, 8, 8'h3C);
    deselect_dut();
    check_reg(3, 8'hC3);

    $display("[TB] address wrap");
    select_dut();
    apply_stimulus(8'h8F, 8, 8'h5A);
    expect_write(4'd15, 8'h11);
    apply_stimulus(8'h11, 8, 8'h00);
    expect_write(4'd0, 8'h22);
    apply_stimulus(8'h22, 8, 8'h00);
    deselect_dut();
    check_reg(15, 8'h11);
    check_reg(0, 8'h22);

    $display("[TB] aborted partial byte");
    select_dut();
    apply_stimulus(8'h82, 8, 8'h5A);
    apply_stimulus(8'hFF, 5, 8'h00);
    nSS = 1'b1;
    wait_clk(3);
    check_output("abort_busy", 32'(BUSY), 32'd0);
    check_output("abort_miso_en", 32'(MISO_EN), 32'd0);
    check_output("abort_miso", 32'(MISO), 32'd1);
    wait_clk(5);
    check_reg(2, 8'h00);

    $display("[TB] reset mid-transfer");
    select_dut();
    apply_stimulus(8'h81, 8, 8'h5A);
    apply_stimulus(8'hAA, 4, 8'h00);
    nRESET = 1'b0;
    #1;
    check_output("midrst_busy", 32'(BUSY), 32'd0);
    check_output("midrst_miso_en", 32'(MISO_EN), 32'd0);
    for (int i = 0; i < NREGS; i++) check_reg(i, 8'h00);
    wait_clk(2);
    nRESET = 1'b1;
    wait_clk(2);
    apply_stimulus(8'hAA, 4, 8'h00);
    check_output("post_rst_busy", 32'(BUSY), 32'd0);
    check_output("post_rst_miso_en", 32'(MISO_EN), 32'd0);
    deselect_dut();
    STATUS = 8'hA5;
    select_dut();
    apply_stimulus(8'h85, 8, 8'hA5);
    expect_write(4'd5, 8'h77);
    apply_stimulus(8'h77, 8, 8'h00);
    deselect_dut();
    check_reg(5, 8'h77);
    check_reg(1, 8'h00);
    select_dut();
    apply_stimulus(8'h05, 8, 8'hA5);
    apply_stimulus(8'h00, 8, 8'h77);
    deselect_dut();

    wait_clk(10);
    check_output("pending_writes", 32'(exp_wr_q.size()), 32'd0);
    check_output("pending_miso", 32'(got_miso_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
